// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: port count, access kind,
// and a width helper usable in parameter expressions.
package ram_port_arbiter_pkg;

  localparam int unsigned RAM_PORTS = 2;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin find-first-set: first set bit of mask scanning
// ptr, ptr+1, ... modulo N.
module rr_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && mask[j[W-1:0]]) begin
        found = 1'b1;
        idx   = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one two-port RAM between NUM_REQ load/store requesters, granting up
// to two requests per cycle round-robin and returning read data per requester.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
  output logic                           ce0,
  output logic                           we0,
  output logic [ADDR_WIDTH-1:0]          address0,
  output logic [DATA_WIDTH-1:0]          mem_din0,
  input  logic [DATA_WIDTH-1:0]          mem_dout0,
  output logic                           ce1,
  output logic                           we1,
  output logic [ADDR_WIDTH-1:0]          address1,
  output logic [DATA_WIDTH-1:0]          mem_din1,
  input  logic [DATA_WIDTH-1:0]          mem_dout1
);

  localparam int unsigned PW = clog2(NUM_REQ);

  logic [PW-1:0]         ptr;
  logic [NUM_REQ-1:0]    rsp_full, inflight;
  logic [DATA_WIDTH-1:0] rsp_data [NUM_REQ];
  logic [RAM_PORTS-1:0]  pend_valid;
  logic [PW-1:0]         pend_id0, pend_id1;

  logic [NUM_REQ-1:0]    elig, mask1, full_nxt, infl_nxt;
  logic                  found0, found1, we_0, we_1;
  logic [PW-1:0]         idx0, idx1;
  logic [ADDR_WIDTH-1:0] addr_0, addr_1;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Grants are suppressed while rst is high so the RAM stays idle in reset.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      elig[i] = !rst && req_valid[i] &&
                (op_e'(req_we[i]) == OP_WRITE || (!rsp_full[i] && !inflight[i]));
  end

  rr_pick #(.N(NUM_REQ), .W(PW)) u_pick0 (
    .mask  (elig),
    .ptr   (ptr),
    .found (found0),
    .idx   (idx0)
  );

  // Port 1 continues the scan past the port 0 winner, skipping any candidate
  // whose address collides with port 0 where either side writes.
  always_comb begin
    int unsigned pos0, posj;
    addr_0 = req_addr[32'(idx0)*ADDR_WIDTH +: ADDR_WIDTH];
    we_0   = req_we[idx0];
    pos0   = (32'(idx0) + NUM_REQ - 32'(ptr)) % NUM_REQ;
    posj   = 0;
    mask1  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      posj     = (j + NUM_REQ - 32'(ptr)) % NUM_REQ;
      mask1[j] = found0 && elig[j] && (posj > pos0) &&
                 !((req_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == addr_0) && (req_we[j] || we_0));
    end
  end

  rr_pick #(.N(NUM_REQ), .W(PW)) u_pick1 (
    .mask  (mask1),
    .ptr   (ptr),
    .found (found1),
    .idx   (idx1)
  );

  always_comb begin
    addr_1    = req_addr[32'(idx1)*ADDR_WIDTH +: ADDR_WIDTH];
    we_1      = req_we[idx1];
    req_ready = '0;
    ce0 = 1'b0; we0 = 1'b0; address0 = '0; mem_din0 = '0;
    ce1 = 1'b0; we1 = 1'b0; address1 = '0; mem_din1 = '0;
    if (found0) begin
      req_ready[idx0] = 1'b1;
      ce0      = 1'b1;
      we0      = we_0;
      address0 = addr_0;
      mem_din0 = req_wdata[32'(idx0)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (found1) begin
      req_ready[idx1] = 1'b1;
      ce1      = 1'b1;
      we1      = we_1;
      address1 = addr_1;
      mem_din1 = req_wdata[32'(idx1)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    full_nxt = rsp_full & ~rsp_ready;
    infl_nxt = inflight;
    if (pend_valid[0]) begin
      full_nxt[pend_id0] = 1'b1;
      infl_nxt[pend_id0] = 1'b0;
    end
    if (pend_valid[1]) begin
      full_nxt[pend_id1] = 1'b1;
      infl_nxt[pend_id1] = 1'b0;
    end
    if (found0 && !we_0) infl_nxt[idx0] = 1'b1;
    if (found1 && !we_1) infl_nxt[idx1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      rsp_full   <= '0;
      inflight   <= '0;
      pend_valid <= '0;
      pend_id0   <= '0;
      pend_id1   <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) rsp_data[i] <= '0;
    end else begin
      rsp_full      <= full_nxt;
      inflight      <= infl_nxt;
      pend_valid[0] <= found0 && !we_0;
      pend_valid[1] <= found1 && !we_1;
      pend_id0      <= idx0;
      pend_id1      <= idx1;
      if (pend_valid[0]) rsp_data[pend_id0] <= mem_dout0;
      if (pend_valid[1]) rsp_data[pend_id1] <= mem_dout1;
      if (found1)      ptr <= next_ptr(idx1);
      else if (found0) ptr <= next_ptr(idx0);
    end
  end

  always_comb begin
    rsp_valid = rsp_full;
    rsp_rdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rsp_data[i];
  end

endmodule
